// File: rtl/fu_operand_regbank.sv
// Register bank and operand/write-back pipeline that feeds the 4-bit
// function unit, with result forwarding, R0 fixed at zero and a halt input.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   halt                  freezes the pipeline, RF and flags
//   cw_valid/cw_ready     control word handshake (cw_ready = ~halt)
//   cw_aa/ba/da           source A, source B and destination addresses
//   cw_mb/cw_const        B operand select (1: constant) and constant
//   cw_fs/cw_rw           function select, register write enable
//   fu_a/fu_b/fu_fs       registered operands and function select
//   fu_f/fu_flags         function unit result and flags
//   flags_q               flags of the last completed op
//   wb_valid/addr/data    write-back pulse, destination and data
//   dbg_addr/dbg_data     combinational debug read (not forwarded)
module fu_operand_regbank #(
    parameter int  N    = 4,
    parameter int  REGS = 8,
    localparam int AW   = $clog2(REGS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          halt,
    input  logic          cw_valid,
    output logic          cw_ready,
    input  logic [AW-1:0] cw_aa,
    input  logic [AW-1:0] cw_ba,
    input  logic [AW-1:0] cw_da,
    input  logic          cw_mb,
    input  logic [N-1:0]  cw_const,
    input  logic [N:0]    cw_fs,
    input  logic          cw_rw,
    output logic [N-1:0]  fu_a,
    output logic [N-1:0]  fu_b,
    output logic [N:0]    fu_fs,
    input  logic [N-1:0]  fu_f,
    input  logic [N-1:0]  fu_flags,
    output logic [N-1:0]  flags_q,
    output logic          wb_valid,
    output logic [AW-1:0] wb_addr,
    output logic [N-1:0]  wb_data,
    input  logic [AW-1:0] dbg_addr,
    output logic [N-1:0]  dbg_data
);

    logic [N-1:0]  rf [REGS];
    logic          op_valid;
    logic          op_rw;
    logic [AW-1:0] op_da;

    logic          accept;
    logic          wr_en;
    logic          hit_a;
    logic          hit_b;
    logic [N-1:0]  rd_a;
    logic [N-1:0]  rd_b;

    assign cw_ready = ~halt;
    assign accept   = cw_valid && !halt;

    // R0 is never written, so it reads its reset value of zero.
    assign wr_en = op_valid && !halt && op_rw
                 && (op_da != '0);

    // The op in EX has not written yet; bypass its result
    // so a dependent word issues without a bubble.
    assign hit_a = op_valid && op_rw
                 && (op_da == cw_aa)
                 && (cw_aa != '0);
    assign hit_b = op_valid && op_rw
                 && (op_da == cw_ba)
                 && (cw_ba != '0);

    assign rd_a = hit_a ? fu_f : rf[cw_aa];
    assign rd_b = hit_b ? fu_f : rf[cw_ba];

    assign dbg_data = rf[dbg_addr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REGS; i++) begin
                rf[i] <= '0;
            end
        end else if (wr_en) begin
            rf[op_da] <= fu_f;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_valid <= 1'b0;
            op_rw    <= 1'b0;
            op_da    <= '0;
            fu_a     <= '0;
            fu_b     <= '0;
            fu_fs    <= '0;
        end else if (!halt) begin
            op_valid <= accept;
            if (accept) begin
                fu_a  <= rd_a;
                fu_b  <= cw_mb ? cw_const : rd_b;
                fu_fs <= cw_fs;
                op_da <= cw_da;
                op_rw <= cw_rw;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q  <= '0;
            wb_valid <= 1'b0;
            wb_addr  <= '0;
            wb_data  <= '0;
        end else begin
            // Pulse only on edges that actually wrote the RF.
            wb_valid <= wr_en;
            if (op_valid && !halt) begin
                flags_q <= fu_flags;
            end
            if (wr_en) begin
                wb_addr <= op_da;
                wb_data <= fu_f;
            end
        end
    end

endmodule

// File: tb/tb_fu_operand_regbank.sv
// Scoreboard bench for fu_operand_regbank with a behavioural function unit
// and a sequential register-file reference model.
module tb_fu_operand_regbank;

    logic       clk;
    logic       rst_n;
    logic       halt;
    logic       cw_valid;
    logic       cw_ready;
    logic [2:0] cw_aa;
    logic [2:0] cw_ba;
    logic [2:0] cw_da;
    logic       cw_mb;
    logic [3:0] cw_const;
    logic [4:0] cw_fs;
    logic       cw_rw;
    logic [3:0] fu_a;
    logic [3:0] fu_b;
    logic [4:0] fu_fs;
    logic [3:0] fu_f;
    logic [3:0] fu_flags;
    logic [3:0] flags_q;
    logic       wb_valid;
    logic [2:0] wb_addr;
    logic [3:0] wb_data;
    logic [2:0] dbg_addr;
    logic [3:0] dbg_data;

    fu_operand_regbank #(.N(4), .REGS(8)) dut (
        .clk(clk), .rst_n(rst_n), .halt(halt),
        .cw_valid(cw_valid), .cw_ready(cw_ready),
        .cw_aa(cw_aa), .cw_ba(cw_ba), .cw_da(cw_da),
        .cw_mb(cw_mb), .cw_const(cw_const),
        .cw_fs(cw_fs), .cw_rw(cw_rw),
        .fu_a(fu_a), .fu_b(fu_b), .fu_fs(fu_fs),
        .fu_f(fu_f), .fu_flags(fu_flags),
        .flags_q(flags_q),
        .wb_valid(wb_valid), .wb_addr(wb_addr),
        .wb_data(wb_data),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural function unit: returns {flags, f}.
    function automatic logic [7:0] fu_fn(
        input logic [3:0] a, input logic [3:0] b,
        input logic [4:0] fs);
        logic [4:0] s;
        logic [3:0] f;
        logic c, v;
        s = '0; c = 1'b0; v = 1'b0;
        case (fs)
            5'b00010: begin
                s = {1'b0, a} + {1'b0, b};
                f = s[3:0]; c = s[4];
                v = (a[3] == b[3]) && (f[3] != a[3]);
            end
            5'b00101: begin
                s = {1'b0, a} + {1'b0, ~b} + 5'd1;
                f = s[3:0]; c = s[4];
                v = (a[3] != b[3]) && (f[3] != a[3]);
            end
            5'b01000: f = a & b;
            5'b01010: f = a | b;
            5'b01100: f = a ^ b;
            5'b10000: f = b;
            5'b10100: f = {a[2:0], 1'b0};
            5'b11000: f = {1'b0, a[3:1]};
            default:  f = a;
        endcase
        return {v, f[3], (f == 4'h0), c, f};
    endfunction

    always_comb {fu_flags, fu_f} = fu_fn(fu_a, fu_b, fu_fs);

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [4:0] fs;
    } ops_t;

    typedef struct {
        logic       wr;
        logic [2:0] da;
        logic [3:0] f;
        logic [3:0] fl;
    } res_t;

    ops_t opq[$];
    res_t resq[$];
    logic [3:0] rf_m [8];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm,
                       input logic [7:0] act,
                       input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm);
        checks++;
        errors++;
        $display("FAIL %s got=none exp=entry", nm);
    endtask

    // Reference: words take effect in issue order; each word sees
    // every earlier word's result (forwarding hides the pipeline).
    task automatic model_issue(
        input logic [2:0] aa, input logic [2:0] ba,
        input logic [2:0] da, input logic mb,
        input logic [3:0] k, input logic [4:0] fs,
        input logic rw);
        ops_t o;
        res_t r;
        logic [7:0] y;
        o.a  = (aa == 3'd0) ? 4'h0 : rf_m[aa];
        o.b  = mb ? k : ((ba == 3'd0) ? 4'h0 : rf_m[ba]);
        o.fs = fs;
        y    = fu_fn(o.a, o.b, fs);
        r.wr = rw && (da != 3'd0);
        r.da = da;
        r.f  = y[3:0];
        r.fl = y[7:4];
        if (r.wr) rf_m[da] = r.f;
        opq.push_back(o);
        resq.push_back(r);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) rf_m[i] = 4'h0;
        opq.delete();
        resq.delete();
    endtask

    // Drives one cycle's inputs, then returns 1 time unit after the edge.
    task automatic step(
        input logic v, input logic h,
        input logic [2:0] aa, input logic [2:0] ba,
        input logic [2:0] da, input logic mb,
        input logic [3:0] k, input logic [4:0] fs,
        input logic rw);
        cw_valid = v; halt = h;
        cw_aa = aa; cw_ba = ba; cw_da = da;
        cw_mb = mb; cw_const = k; cw_fs = fs; cw_rw = rw;
        if (v && !h && rst_n) model_issue(aa, ba, da, mb, k, fs, rw);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 4'h0, 5'd0, 1'b0);
    endtask

    task automatic dbg_chk(input string nm,
                           input logic [2:0] a,
                           input logic [3:0] e);
        dbg_addr = a;
        #1;
        chk(nm, {4'h0, dbg_data}, {4'h0, e});
    endtask

    // Monitor: checks operands and write-back against queued expectations.
    initial begin : monitor
        ops_t lo;
        ops_t o;
        res_t r;
        logic acc, hl, rok, pend;
        pend = 1'b0;
        lo = '{a: 4'h0, b: 4'h0, fs: 5'd0};
        forever begin
            @(posedge clk);
            acc = cw_valid && !halt;
            hl  = halt;
            rok = rst_n;
            @(negedge clk);
            chk("cw_ready", {7'd0, cw_ready}, {7'd0, !halt});
            if (!rok) begin
                pend = 1'b0;
                lo = '{a: 4'h0, b: 4'h0, fs: 5'd0};
                continue;
            end
            if (hl) begin
                chk("hold_a", {4'h0, fu_a}, {4'h0, lo.a});
                chk("hold_b", {4'h0, fu_b}, {4'h0, lo.b});
                chk("hold_fs", {3'd0, fu_fs}, {3'd0, lo.fs});
            end else begin
                if (pend) begin
                    if (resq.size() == 0) fail("resq_empty");
                    else begin
                        r = resq.pop_front();
                        chk("flags_q", {4'h0, flags_q}, {4'h0, r.fl});
                        chk("wb_valid", {7'd0, wb_valid}, {7'd0, r.wr});
                        if (r.wr) begin
                            chk("wb_addr", {5'd0, wb_addr}, {5'd0, r.da});
                            chk("wb_data", {4'h0, wb_data}, {4'h0, r.f});
                        end
                    end
                    pend = 1'b0;
                end else begin
                    chk("wb_idle", {7'd0, wb_valid}, 8'd0);
                end
                if (acc) begin
                    if (opq.size() == 0) fail("opq_empty");
                    else begin
                        o = opq.pop_front();
                        chk("fu_a", {4'h0, fu_a}, {4'h0, o.a});
                        chk("fu_b", {4'h0, fu_b}, {4'h0, o.b});
                        chk("fu_fs", {3'd0, fu_fs}, {3'd0, o.fs});
                        lo = o;
                    end
                    pend = 1'b1;
                end
            end
        end
    end

    localparam logic [4:0] ADD  = 5'b00010;
    localparam logic [4:0] PASB = 5'b10000;

    logic [4:0] fs_tab [8];

    initial begin : driver
        fs_tab = '{5'b00000, 5'b00010, 5'b00101, 5'b01000,
                   5'b01010, 5'b01100, 5'b10100, 5'b11000};
        rst_n = 1'b0; halt = 1'b0; cw_valid = 1'b0;
        cw_aa = '0; cw_ba = '0; cw_da = '0; cw_mb = 1'b0;
        cw_const = '0; cw_fs = '0; cw_rw = 1'b0; dbg_addr = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        chk("rst_fu_a", {4'h0, fu_a}, 8'd0);
        chk("rst_fu_b", {4'h0, fu_b}, 8'd0);
        chk("rst_flags", {4'h0, flags_q}, 8'd0);
        chk("rst_ready", {7'd0, cw_ready}, 8'd1);
        for (int i = 0; i < 8; i++) dbg_chk("rst_rf", 3'(i), 4'h0);

        // constant loads
        step(1, 0, 3'd0, 3'd0, 3'd3, 1, 4'h5, ADD, 1);
        idle(2);
        dbg_chk("const_r3", 3'd3, 4'h5);
        step(1, 0, 3'd0, 3'd0, 3'd4, 1, 4'h2, ADD, 1);

        // back-to-back dependency through forwarding
        step(1, 0, 3'd3, 3'd4, 3'd5, 0, 4'h0, ADD, 1);
        step(1, 0, 3'd5, 3'd4, 3'd6, 0, 4'h0, ADD, 1);
        chk("fwd_a", {4'h0, fu_a}, 8'd7);
        idle(2);
        dbg_chk("dep_r6", 3'd6, 4'h9);

        // write to R0 is dropped, flags still update
        step(1, 0, 3'd0, 3'd0, 3'd0, 1, 4'hF, PASB, 1);
        idle(2);
        dbg_chk("r0_zero", 3'd0, 4'h0);
        chk("r0_flags", {4'h0, flags_q}, 8'h04);

        // halt with a word in OF
        dbg_addr = 3'd2;
        step(1, 0, 3'd3, 3'd0, 3'd2, 1, 4'h1, ADD, 1);
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 3'd1, 3'd1, 3'd1, 1, 4'h7, ADD, 1);
            chk("halt_ready", {7'd0, cw_ready}, 8'd0);
            dbg_chk("halt_r2", 3'd2, 4'h0);
        end
        idle(1);
        dbg_chk("post_halt_r2", 3'd2, 4'h6);

        // asynchronous reset between OF and WB
        dbg_addr = 3'd6;
        step(1, 0, 3'd6, 3'd0, 3'd7, 1, 4'h1, ADD, 1);
        cw_valid = 1'b0;
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_fu_a", {4'h0, fu_a}, 8'd0);
        chk("arst_fu_b", {4'h0, fu_b}, 8'd0);
        chk("arst_fu_fs", {3'd0, fu_fs}, 8'd0);
        chk("arst_flags", {4'h0, flags_q}, 8'd0);
        chk("arst_wb_addr", {5'd0, wb_addr}, 8'd0);
        chk("arst_wb_data", {4'h0, wb_data}, 8'd0);
        chk("arst_rf6", {4'h0, dbg_data}, 8'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);
        for (int i = 0; i < 8; i++) dbg_chk("arst_rf", 3'(i), 4'h0);

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(9) < 7) ? 1'b1 : 1'b0,
                 ($urandom_range(9) < 2) ? 1'b1 : 1'b0,
                 3'($urandom_range(7)), 3'($urandom_range(7)),
                 3'($urandom_range(7)), 1'($urandom_range(1)),
                 4'($urandom_range(15)),
                 fs_tab[$urandom_range(7)],
                 ($urandom_range(3) != 0) ? 1'b1 : 1'b0);
        end
        idle(3);
        for (int i = 0; i < 8; i++) dbg_chk("final_rf", 3'(i), rf_m[i]);
        chk("opq_drained", 8'(opq.size()), 8'd0);
        chk("resq_drained", 8'(resq.size()), 8'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/fu_operand_regbank.md
Name: fu_operand_regbank

Overview:
Register bank and operand/writeback pipeline placed directly in front of the 4-bit function unit (ALU/shifter). It accepts control words (source/destination addresses, function select, write enable, constant), reads two operands from an internal register file, and registers them with the function select into the unit's A/B/FS inputs. One cycle later it writes the unit's F result back and latches its flags. Includes a halt handshake, R0 hardwired to zero, and result forwarding for back-to-back dependencies.

Parameters:
N, 4, datapath width; matches the function unit's N (FS is N+1 bits, flags are N bits)
REGS, 8, number of registers; address width AW = $clog2(REGS)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
halt  in  1  freeze the whole pipeline while high
cw_valid  in  1  control word present
cw_ready  out  1  control word accepted when cw_valid && cw_ready; equals ~halt
cw_aa  in  AW  source A register address
cw_ba  in  AW  source B register address
cw_da  in  AW  destination register address
cw_mb  in  1  1: B operand = cw_const; 0: B operand = RF[cw_ba]
cw_const  in  N  constant operand
cw_fs  in  N+1  function select forwarded to the unit
cw_rw  in  1  write result to RF[cw_da]
fu_a  out  N  registered A operand to the function unit
fu_b  out  N  registered B operand to the function unit
fu_fs  out  N+1  registered function select
fu_f  in  N  function unit result (combinational from fu_a/fu_b/fu_fs)
fu_flags  in  N  function unit flags {over,neg,zero,carr}
flags_q  out  N  last latched flags
wb_valid  out  1  one-cycle pulse: a write-back occurred at this edge
wb_addr  out  AW  destination of the last write-back
wb_data  out  N  data of the last write-back
dbg_addr  in  AW  debug read address
dbg_data  out  N  RF[dbg_addr], combinational

Behaviour:
- Reset (async, rst_n=0): all RF entries, fu_a, fu_b, fu_fs, flags_q, wb_addr, and wb_data go to 0. The op_valid, op_rw, wb_valid, and op_da pipeline registers also clear. Release is synchronous to the next edge.
- Stage OF, at the edge where cw_valid && cw_ready:
  - Capture fu_a = RFfwd[cw_aa].
  - Capture fu_b = cw_mb ? cw_const : RFfwd[cw_ba].
  - Capture fu_fs = cw_fs, op_da = cw_da, op_rw = cw_rw, and set op_valid = 1.
  - If no word is accepted and halt=0, op_valid = 0; fu_a, fu_b, and fu_fs hold their values.
- Stage EX/WB, at the edge where op_valid && !halt:
  - If op_rw && op_da != 0: RF[op_da] <= fu_f, and wb_valid pulses 1 with wb_addr = op_da, wb_data = fu_f.
  - flags_q <= fu_flags for every valid op, whether or not it writes.
  - Otherwise wb_valid = 0.
- Latency: a word accepted at edge k presents operands from k. Its result is in the RF and flags_q after edge k+1. Throughput is one word per cycle.
- Forwarding: RFfwd[x] = fu_f when op_valid && op_rw && op_da == x && x != 0; otherwise RF[x]. This resolves a dependency on the immediately preceding word with zero bubbles.
- R0 always reads 0. Writes to R0 are dropped, wb_valid stays 0, and R0 is never forwarded.
- Halt: while halt=1, all pipeline registers, the RF, and flags_q hold, and cw_ready = 0. A pending op completes on the first edge after halt falls.
- Simultaneous cases:
  - A WB write and an OF read of the same register in one cycle: forwarding returns the new value.
  - dbg_data shows the pre-edge RF contents; it is not forwarded.
- Widths: all datapaths are N bits. No arithmetic is done here; cw_const and fu_f pass through unmodified.
- Reset mid-operation: an in-flight op is discarded, no write-back occurs, and flags_q is cleared.

Test Plan:
- Reset then read all registers via dbg_addr 0..7 -> every dbg_data = 0; fu_a = fu_b = 0; flags_q = 0; cw_ready = 1.
- Constant load: cw_mb=1, cw_const=4'h5, cw_aa=0, cw_fs=5'b00010 (F=A+B), cw_rw=1, cw_da=3 -> after two edges RF[3]=5, wb_valid pulse with wb_addr=3, wb_data=5.
- Back-to-back dependency:
  - Setup: R3=5, R4=2 preloaded.
  - Word 1: R5 = R3 + R4.
  - Word 2, next cycle: R6 = R5 + R4 (aa=5).
  - Required: fu_a = 7 for word 2 via forwarding; final R6 = 9 with no stall.
- R0 protection: cw_da=0, cw_rw=1, F=4'hF -> wb_valid stays 0, dbg_data(0) = 0, flags_q still updates.
- Halt: assert halt for 3 cycles with a word in OF -> fu_* and the RF unchanged, cw_ready=0; write-back occurs on the first edge after halt deasserts.
- Async reset mid-op: drop rst_n between OF and WB -> no RF write; all outputs 0 immediately, without waiting for a clock edge.
